// File: rtl/freq_generator.sv
// Programmable square-wave and measurement-gate source for the frequency counter.
// Publishes the number of signal_out rising edges seen inside each gate window.
module freq_generator #(
  parameter int unsigned GATE_CYCLES         = 50_000_000,
  parameter int unsigned GAP_CYCLES          = 1_000,
  parameter int unsigned DEFAULT_HALF_PERIOD = 25_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] half_period,
  input  logic        load,
  input  logic        enable,
  output logic        signal_out,
  output logic        gate_out,
  output logic [29:0] expected_count,
  output logic        count_valid
);

  localparam int unsigned CW = 30;
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] GATE_LAST = CW'(GATE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] HP_RESET  = CW'(DEFAULT_HALF_PERIOD);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_GATE_HIGH = 2'd1;
  localparam logic [1:0] ST_GATE_LOW  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] gcnt_q, gcnt_d;
  logic [CW-1:0] hp_active_q, hp_active_d;
  logic [CW-1:0] pend_hp_q, pend_hp_d;
  logic          pending_q, pending_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          signal_q, signal_d;
  logic          gate_q, gate_d;
  logic [CW-1:0] edge_cnt_q, edge_cnt_d;
  logic [CW-1:0] exp_cnt_q, exp_cnt_d;
  logic          valid_q, valid_d;

  logic          clear_cnt;
  logic          close_win;
  logic          rise;
  logic [CW-1:0] edge_base;

  // Divider: a pending half-period only takes effect on a toggle, so no runt half-cycle.
  always_comb begin
    hp_active_d = hp_active_q;
    pend_hp_d   = pend_hp_q;
    pending_d   = pending_q;
    div_cnt_d   = div_cnt_q;
    signal_d    = signal_q;
    if (hp_active_q == '0) begin
      signal_d  = 1'b0;
      div_cnt_d = '0;
      if (pending_q) begin
        hp_active_d = pend_hp_q;
        pending_d   = 1'b0;
      end
    end else if (div_cnt_q == hp_active_q - CW'(1)) begin
      signal_d  = ~signal_q;
      div_cnt_d = '0;
      if (pending_q) begin
        hp_active_d = pend_hp_q;
        pending_d   = 1'b0;
      end
    end else begin
      div_cnt_d = div_cnt_q + CW'(1);
    end
    if (load) begin
      pend_hp_d = half_period;
      pending_d = 1'b1;
    end
  end

  // Gate FSM: windows always run to completion once started.
  always_comb begin
    state_d   = state_q;
    gcnt_d    = gcnt_q;
    clear_cnt = 1'b0;
    close_win = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d   = ST_GATE_HIGH;
          gcnt_d    = '0;
          clear_cnt = 1'b1;
        end
      end
      ST_GATE_HIGH: begin
        if (gcnt_q == GATE_LAST) begin
          state_d   = ST_GATE_LOW;
          gcnt_d    = '0;
          close_win = 1'b1;
        end else begin
          gcnt_d = gcnt_q + CW'(1);
        end
      end
      ST_GATE_LOW: begin
        if (gcnt_q == GAP_LAST) begin
          gcnt_d = '0;
          if (enable) begin
            state_d   = ST_GATE_HIGH;
            clear_cnt = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gcnt_d = gcnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    gate_d = (state_d == ST_GATE_HIGH);
  end

  // An edge counts when the gate is high after the same clock, as a downstream counter sees it.
  always_comb begin
    rise       = ~signal_q & signal_d;
    edge_base  = clear_cnt ? '0 : edge_cnt_q;
    edge_cnt_d = edge_base;
    if (rise && gate_d && (edge_base != CNT_MAX)) begin
      edge_cnt_d = edge_base + CW'(1);
    end
    exp_cnt_d = close_win ? edge_cnt_d : exp_cnt_q;
    valid_d   = close_win;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gcnt_q      <= '0;
      hp_active_q <= HP_RESET;
      pend_hp_q   <= '0;
      pending_q   <= 1'b0;
      div_cnt_q   <= '0;
      signal_q    <= 1'b0;
      gate_q      <= 1'b0;
      edge_cnt_q  <= '0;
      exp_cnt_q   <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gcnt_q      <= gcnt_d;
      hp_active_q <= hp_active_d;
      pend_hp_q   <= pend_hp_d;
      pending_q   <= pending_d;
      div_cnt_q   <= div_cnt_d;
      signal_q    <= signal_d;
      gate_q      <= gate_d;
      edge_cnt_q  <= edge_cnt_d;
      exp_cnt_q   <= exp_cnt_d;
      valid_q     <= valid_d;
    end
  end

  assign signal_out     = signal_q;
  assign gate_out       = gate_q;
  assign expected_count = exp_cnt_q;
  assign count_valid    = valid_q;

endmodule

// File: tb/tb_freq_generator.sv
// Directed bench for freq_generator with a 100-clock gate and 20-clock gap.
module tb_freq_generator;

  logic        clk;
  logic        reset;
  logic [29:0] half_period;
  logic        load;
  logic        enable;
  logic        signal_out;
  logic        gate_out;
  logic [29:0] expected_count;
  logic        count_valid;

  int checks;
  int failures;

  freq_generator #(
    .GATE_CYCLES(100),
    .GAP_CYCLES(20),
    .DEFAULT_HALF_PERIOD(25_000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .half_period(half_period),
    .load(load),
    .enable(enable),
    .signal_out(signal_out),
    .gate_out(gate_out),
    .expected_count(expected_count),
    .count_valid(count_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Waits for the next count_valid pulse; returns the count and cycles waited.
  task automatic wait_valid(input string tag, input int budget, output logic [29:0] cnt,
                            output int cyc);
    cyc = 0;
    cnt = '0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!count_valid && cyc < budget);
    if (!count_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
    cnt = expected_count;
  endtask

  task automatic load_hp(input logic [29:0] hp);
    half_period = hp;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Shortest and longest complete constant stretches of signal_out over n cycles.
  task automatic measure_runs(input int n, output int rmin, output int rmax);
    logic prev;
    int   run;
    bit   started;
    prev = signal_out;
    run = 0;
    started = 0;
    rmin = 999;
    rmax = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (signal_out != prev) begin
        if (started) begin
          if (run < rmin) rmin = run;
          if (run > rmax) rmax = run;
        end
        started = 1;
        run = 1;
        prev = signal_out;
      end else begin
        run++;
      end
    end
  endtask

  logic [29:0] cnt;
  int          cyc;
  int          n;
  int          rmin;
  int          rmax;
  int          hi;
  int          stray;

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    half_period = '0;
    load = 1'b0;
    enable = 1'b0;

    // 1: reset values and default 25_000-clock half-period
    @(negedge clk);
    @(negedge clk);
    check("rst_signal", 32'(signal_out), 32'd0);
    check("rst_gate", 32'(gate_out), 32'd0);
    check("rst_count", 32'(expected_count), 32'd0);
    check("rst_valid", 32'(count_valid), 32'd0);
    reset = 1'b0;
    n = 0;
    stray = 0;
    while (!signal_out && n < 30000) begin
      @(negedge clk);
      n++;
      if (gate_out || count_valid) stray++;
    end
    check("t1_first_toggle", 32'(n), 32'd25000);
    check("t1_idle_gate", 32'(stray), 32'd0);

    // 2: half_period 5 applied at the next toggle, then 10 edges per window
    load_hp(30'd5);
    n = 0;
    while (signal_out && n < 26000) begin
      @(negedge clk);
      n++;
    end
    check("t2_hp_applied", 32'(signal_out), 32'd0);
    enable = 1'b1;
    wait_valid("t2_w1", 200, cnt, cyc);
    check("t2_first_latency", 32'(cyc), 32'd101);
    check("t2_w1_count", 32'(cnt), 32'd10);
    for (int w = 0; w < 2; w++) begin
      wait_valid("t2_wn", 200, cnt, cyc);
      check("t2_interval", 32'(cyc), 32'd120);
      check("t2_wn_count", 32'(cnt), 32'd10);
    end

    // 3: switch to half_period 2 mid-run, no runt or stretched half-cycles
    load_hp(30'd2);
    measure_runs(60, rmin, rmax);
    check("t3_run_min", 32'(rmin), 32'd2);
    check("t3_run_max", 32'(rmax), 32'd2);
    wait_valid("t3_w", 200, cnt, cyc);
    check("t3_count", 32'(cnt), 32'd25);

    // 4: half_period 0 holds the output low, then 1 toggles every clock
    load_hp(30'd0);
    repeat (5) @(negedge clk);
    check("t4_held_low", 32'(signal_out), 32'd0);
    wait_valid("t4_w0", 200, cnt, cyc);
    check("t4_zero_count", 32'(cnt), 32'd0);
    load_hp(30'd1);
    check("t4_hp1_c1", 32'(signal_out), 32'd0);
    @(negedge clk);
    check("t4_hp1_c2", 32'(signal_out), 32'd0);
    @(negedge clk);
    check("t4_hp1_c3", 32'(signal_out), 32'd1);
    @(negedge clk);
    check("t4_hp1_c4", 32'(signal_out), 32'd0);
    wait_valid("t4_w1", 200, cnt, cyc);
    check("t4_hp1_count", 32'(cnt), 32'd50);

    // 5: dropping enable mid-window does not truncate it; FSM then idles
    n = 0;
    while (!gate_out && n < 40) begin
      @(negedge clk);
      n++;
    end
    hi = 0;
    while (gate_out && hi < 200) begin
      hi++;
      if (hi == 30) enable = 1'b0;
      @(negedge clk);
    end
    check("t5_gate_len", 32'(hi), 32'd100);
    check("t5_valid", 32'(count_valid), 32'd1);
    check("t5_count", 32'(expected_count), 32'd50);
    stray = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (gate_out || count_valid) stray++;
    end
    check("t5_idle_after", 32'(stray), 32'd0);

    // 6: edge counter saturates instead of wrapping
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    force dut.edge_cnt_q = 30'h3FFF_FFF0;
    @(negedge clk);
    release dut.edge_cnt_q;
    wait_valid("t6_w", 200, cnt, cyc);
    check("t6_saturate", 32'(cnt), 32'h3FFF_FFFF);

    // 5b: reset mid-window clears everything at once
    wait_valid("t5b_w", 200, cnt, cyc);
    check("t5b_count", 32'(cnt), 32'd50);
    n = 0;
    while (!gate_out && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5b_signal", 32'(signal_out), 32'd0);
    check("t5b_gate", 32'(gate_out), 32'd0);
    check("t5b_count_rst", 32'(expected_count), 32'd0);
    check("t5b_valid", 32'(count_valid), 32'd0);
    enable = 1'b0;
    stray = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (count_valid || gate_out) stray++;
    end
    reset = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (count_valid || gate_out) stray++;
    end
    check("t5b_quiet", 32'(stray), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
